cx_req_arbiter: RTL

Round-robin arbiter that lets N_REQ CX requesters, such as several Ibex cores or a core plus an accelerator DMA, share one CX switch port and its CXUs. It grants one requester at a time and holds exactly one transaction in flight. It routes the switch response back to the owning requester and returns a timeout status if the switch never answers. It sits between the requesters' CX interfaces and the switch's Ibex-side CX port.

---
 rtl/cx_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/cx_req_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cx_pkg.sv
// Shared CX definitions: arbiter FSM states, status codes and datapath widths.
package cx_pkg;

    localparam int unsigned CX_DATA_W   = 32;
    localparam int unsigned CX_STATUS_W = 4;

    localparam logic [CX_STATUS_W-1:0] CX_STATUS_OK      = 4'h0;
    localparam logic [CX_STATUS_W-1:0] CX_STATUS_TIMEOUT = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DELIVER
    } cx_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request searching from
// ptr+1 with wrap-around wins.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    // Scan the N positions after ptr and keep the first requester found.
    always_comb begin
        int unsigned cand;
        gnt       = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!any_valid && req[cand]) begin
                any_valid = 1'b1;
                idx       = IW'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cx_req_arbiter.sv
// Round-robin arbiter sharing one CX switch port among N_REQ requesters with
// a single transaction in flight, response routing and a response timeout.
module cx_req_arbiter
    import cx_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [2*N_REQ-1:0]           req_cxu_id,
    input  logic [2*N_REQ-1:0]           req_state_id,
    input  logic [CX_DATA_W*N_REQ-1:0]   req_data0,
    input  logic [CX_DATA_W*N_REQ-1:0]   req_data1,
    output logic [N_REQ-1:0]             resp_valid,
    input  logic [N_REQ-1:0]             resp_ready,
    output logic [CX_DATA_W-1:0]         resp_data,
    output logic [CX_STATUS_W-1:0]       resp_status,
    output logic                         ds_req_valid,
    input  logic                         ds_req_ready,
    output logic [1:0]                   ds_cxu_id,
    output logic [1:0]                   ds_state_id,
    output logic [CX_DATA_W-1:0]         ds_data0,
    output logic [CX_DATA_W-1:0]         ds_data1,
    input  logic                         ds_resp_valid,
    output logic                         ds_resp_ready,
    input  logic [CX_DATA_W-1:0]         ds_resp_data,
    input  logic [CX_STATUS_W-1:0]       ds_resp_status,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         stray_resp
);

    localparam int unsigned   IW       = $clog2(N_REQ);
    localparam int unsigned   TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    cx_arb_state_e    state;
    logic [IW-1:0]    rr_ptr;
    logic [TW-1:0]    timer;
    logic [N_REQ-1:0] win_gnt;
    logic [IW-1:0]    win_idx;
    logic             win_any;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .gnt       (win_gnt),
        .idx       (win_idx),
        .any_valid (win_any)
    );

    // Accept the winner combinationally in IDLE; nothing is accepted in reset.
    always_comb begin
        req_ready = '0;
        if (rst && state == IDLE) begin
            req_ready = win_gnt;
        end
    end

    // Drain the switch response channel everywhere except while delivering.
    always_comb begin
        ds_resp_ready = rst && (state != DELIVER);
    end

    // Transaction FSM; the response registers double as the delivery latches
    // so resp_data/resp_status read zero outside DELIVER.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= IW'(N_REQ - 1);
            timer        <= '0;
            grant_id     <= '0;
            ds_req_valid <= 1'b0;
            ds_cxu_id    <= '0;
            ds_state_id  <= '0;
            ds_data0     <= '0;
            ds_data1     <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            resp_status  <= CX_STATUS_OK;
            stray_resp   <= 1'b0;
        end else begin
            stray_resp <= ds_resp_valid && (state == IDLE || state == ISSUE);
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        ds_cxu_id    <= req_cxu_id[2*win_idx +: 2];
                        ds_state_id  <= req_state_id[2*win_idx +: 2];
                        ds_data0     <= req_data0[CX_DATA_W*win_idx +: CX_DATA_W];
                        ds_data1     <= req_data1[CX_DATA_W*win_idx +: CX_DATA_W];
                        grant_id     <= win_idx;
                        ds_req_valid <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ds_req_ready) begin
                        ds_req_valid <= 1'b0;
                        timer        <= '0;
                        state        <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A response in the timeout cycle takes priority.
                    if (ds_resp_valid) begin
                        resp_data   <= ds_resp_data;
                        resp_status <= ds_resp_status;
                        resp_valid  <= N_REQ'(1) << grant_id;
                        state       <= DELIVER;
                    end else if (TIMEOUT != 0 && timer == TMO_LAST) begin
                        resp_data   <= '0;
                        resp_status <= CX_STATUS_TIMEOUT;
                        resp_valid  <= N_REQ'(1) << grant_id;
                        state       <= DELIVER;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                DELIVER: begin
                    if (resp_ready[grant_id]) begin
                        resp_valid  <= '0;
                        resp_data   <= '0;
                        resp_status <= CX_STATUS_OK;
                        rr_ptr      <= grant_id;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
